// File: rtl/nav_pkg.sv
// Shared types and speed constants for the navigation command sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package nav_pkg;

    // Sequencer modes: idle, turning in place, ramping up, ramping down.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HDNG  = 2'd1,
        ACCEL = 2'd2,
        DECEL = 2'd3
    } nav_state_t;

    // Default speed profile; units are PID forward-speed counts.
    localparam logic [10:0] MAX_FRWRD = 11'h2A0;
    localparam logic [10:0] MIN_FRWRD = 11'h0D0;

    // The large step lets a simulated move reach cruise in a few dozen
    // gyro samples; the small step is the real-hardware ramp.
    localparam logic [10:0] INC_FAST  = 11'h018;
    localparam logic [10:0] INC_SLOW  = 11'h002;

    // Picks the per-sample acceleration step.
    function automatic logic [10:0] spd_inc(input logic fast);
        return fast ? INC_FAST : INC_SLOW;
    endfunction

endpackage

// File: rtl/nav_seq_spd_ramp.sv
// Registered forward-speed ramp: load-min, saturating add, floored subtract, clear.
// Latency: one cycle from a control strobe to the new speed on spd.
// Backpressure: none; strobes are applied on the edge they are seen.
module spd_ramp
    import nav_pkg::*;
#(
    parameter logic [10:0] MIN_SPD  = MIN_FRWRD,
    parameter logic [10:0] MAX_SPD  = MAX_FRWRD,
    parameter logic [10:0] STEP_INC = INC_FAST
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        ld_min,
    input  logic        inc_en,
    input  logic        dec_en,
    output logic [10:0] spd,
    output logic        le_dec
);

    // Deceleration is four times as aggressive as acceleration.
    localparam logic [10:0] STEP_DEC = STEP_INC << 2;

    logic [10:0] spd_q;
    logic [10:0] spd_d;
    logic [11:0] spd_sum;

    // Next speed: clear beats load beats add beats subtract.
    always_comb begin
        // The extra bit keeps the sum from wrapping before the clamp.
        spd_sum = {1'b0, spd_q} + {1'b0, STEP_INC};
        spd_d   = spd_q;
        if (clr) begin
            spd_d = '0;
        end else if (ld_min) begin
            spd_d = MIN_SPD;
        end else if (inc_en) begin
            spd_d = (spd_sum > {1'b0, MAX_SPD}) ? MAX_SPD : spd_sum[10:0];
        end else if (dec_en) begin
            spd_d = (spd_q <= STEP_DEC) ? 11'd0 : (spd_q - STEP_DEC);
        end
    end

    // Speed register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            spd_q <= '0;
        end else begin
            spd_q <= spd_d;
        end
    end

    assign spd    = spd_q;
    // Tells the FSM that the next decrement lands on (or below) zero.
    assign le_dec = (spd_q <= STEP_DEC);

endmodule

// File: rtl/nav_seq.sv
// Command sequencer: turns to a heading or runs a ramped forward move for the PID block.
// Latency: accepted command visible on outputs one cycle after strt_*; mv_cmplt one cycle after the finishing sample.
// Backpressure: none; commands arriving while busy are dropped, hard_stp aborts a move on the next edge.
module nav_seq #(
    parameter logic        FAST_SIM  = 1'b1,
    parameter logic [10:0] MAX_FRWRD = nav_pkg::MAX_FRWRD,
    parameter logic [10:0] MIN_FRWRD = nav_pkg::MIN_FRWRD,
    parameter int          SETTLE    = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        strt_hdng,
    input  logic        strt_mv,
    input  logic        stp_mv,
    input  logic        hard_stp,
    input  logic [11:0] cmd_hdng,
    input  logic        hdng_vld,
    input  logic        at_hdng,
    output logic [11:0] dsrd_hdng,
    output logic [10:0] frwrd_spd,
    output logic        moving,
    output logic        busy,
    output logic        mv_cmplt
);

    import nav_pkg::*;

    localparam logic [10:0] INC = spd_inc(FAST_SIM);
    localparam int          CW  = $clog2(SETTLE + 1);

    nav_state_t    state_q,     state_d;
    logic [CW-1:0] settle_q,    settle_d;
    logic [CW-1:0] settle_inc;
    logic [11:0]   dsrd_hdng_q, dsrd_hdng_d;
    logic          moving_q,    moving_d;
    logic          busy_q,      busy_d;
    logic          mv_cmplt_q,  mv_cmplt_d;

    logic          ramp_clr;
    logic          ramp_ld_min;
    logic          ramp_inc;
    logic          ramp_dec;
    logic          ramp_le_dec;

    // Speed datapath; the FSM only issues strobes and reads the floor flag.
    spd_ramp #(
        .MIN_SPD  (MIN_FRWRD),
        .MAX_SPD  (MAX_FRWRD),
        .STEP_INC (INC)
    ) u_spd_ramp (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (ramp_clr),
        .ld_min (ramp_ld_min),
        .inc_en (ramp_inc),
        .dec_en (ramp_dec),
        .spd    (frwrd_spd),
        .le_dec (ramp_le_dec)
    );

    // Next-state, settle counter, heading latch and ramp strobes.
    always_comb begin
        state_d     = state_q;
        settle_d    = settle_q;
        dsrd_hdng_d = dsrd_hdng_q;
        mv_cmplt_d  = 1'b0;
        ramp_clr    = 1'b0;
        ramp_ld_min = 1'b0;
        ramp_inc    = 1'b0;
        ramp_dec    = 1'b0;
        settle_inc  = settle_q + CW'(1);

        case (state_q)
            IDLE: begin
                // A turn request outranks a move request in the same cycle.
                if (strt_hdng) begin
                    dsrd_hdng_d = cmd_hdng;
                    settle_d    = '0;
                    state_d     = HDNG;
                end else if (strt_mv) begin
                    ramp_ld_min = 1'b1;
                    state_d     = ACCEL;
                end
            end

            HDNG: begin
                // Only consecutive on-heading samples count toward settling.
                if (hdng_vld) begin
                    if (at_hdng) begin
                        settle_d = settle_inc;
                        if (settle_inc == CW'(SETTLE)) begin
                            settle_d   = '0;
                            mv_cmplt_d = 1'b1;
                            state_d    = IDLE;
                        end
                    end else begin
                        settle_d = '0;
                    end
                end
            end

            ACCEL: begin
                if (hard_stp) begin
                    ramp_clr   = 1'b1;
                    mv_cmplt_d = 1'b1;
                    state_d    = IDLE;
                end else begin
                    // A stop request coinciding with a sample still takes
                    // that sample's increment before ramping down.
                    ramp_inc = hdng_vld;
                    if (stp_mv) begin
                        state_d = DECEL;
                    end
                end
            end

            DECEL: begin
                if (hard_stp) begin
                    ramp_clr   = 1'b1;
                    mv_cmplt_d = 1'b1;
                    state_d    = IDLE;
                end else if (hdng_vld) begin
                    if (ramp_le_dec) begin
                        ramp_clr   = 1'b1;
                        mv_cmplt_d = 1'b1;
                        state_d    = IDLE;
                    end else begin
                        ramp_dec = 1'b1;
                    end
                end
            end

            default: begin
                ramp_clr = 1'b1;
                state_d  = IDLE;
            end
        endcase

        // Status outputs are registered copies of the next-state decode so
        // busy falls in the same cycle mv_cmplt rises.
        busy_d   = (state_d != IDLE);
        moving_d = (state_d != IDLE);
    end

    // FSM and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            settle_q    <= '0;
            dsrd_hdng_q <= '0;
            moving_q    <= 1'b0;
            busy_q      <= 1'b0;
            mv_cmplt_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            settle_q    <= settle_d;
            dsrd_hdng_q <= dsrd_hdng_d;
            moving_q    <= moving_d;
            busy_q      <= busy_d;
            mv_cmplt_q  <= mv_cmplt_d;
        end
    end

    assign dsrd_hdng = dsrd_hdng_q;
    assign moving    = moving_q;
    assign busy      = busy_q;
    assign mv_cmplt  = mv_cmplt_q;

endmodule

// File: tb/tb_nav_seq.sv
// Self-checking bench for nav_seq with a behavioural command model.
// Latency: n/a.
// Backpressure: n/a.
module tb_nav_seq;

    localparam int MIN_S  = 208;   // 0x0D0
    localparam int MAX_S  = 672;   // 0x2A0
    localparam int INC_S  = 24;    // 0x018
    localparam int DEC_S  = 96;    // 0x060
    localparam int SETTLE = 4;

    localparam int M_IDLE = 0;
    localparam int M_TURN = 1;
    localparam int M_UP   = 2;
    localparam int M_DOWN = 3;

    logic        clk;
    logic        rst_n;
    logic        strt_hdng;
    logic        strt_mv;
    logic        stp_mv;
    logic        hard_stp;
    logic [11:0] cmd_hdng;
    logic        hdng_vld;
    logic        at_hdng;
    logic [11:0] dsrd_hdng;
    logic [10:0] frwrd_spd;
    logic        moving;
    logic        busy;
    logic        mv_cmplt;

    int n_tests;
    int n_fail;

    // Reference model state
    int          m_mode;
    int          m_spd;
    int          m_cnt;
    logic [11:0] m_hdng;
    logic        m_cmplt;

    nav_seq #(
        .FAST_SIM  (1'b1),
        .MAX_FRWRD (11'h2A0),
        .MIN_FRWRD (11'h0D0),
        .SETTLE    (SETTLE)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .strt_hdng (strt_hdng),
        .strt_mv   (strt_mv),
        .stp_mv    (stp_mv),
        .hard_stp  (hard_stp),
        .cmd_hdng  (cmd_hdng),
        .hdng_vld  (hdng_vld),
        .at_hdng   (at_hdng),
        .dsrd_hdng (dsrd_hdng),
        .frwrd_spd (frwrd_spd),
        .moving    (moving),
        .busy      (busy),
        .mv_cmplt  (mv_cmplt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit expired (tests=%0d)", n_tests);
        $fatal(1, "watchdog");
    end

    task automatic model_reset();
        m_mode  = M_IDLE;
        m_spd   = 0;
        m_cnt   = 0;
        m_hdng  = '0;
        m_cmplt = 1'b0;
    endtask

    task automatic model_stop();
        m_spd   = 0;
        m_mode  = M_IDLE;
        m_cmplt = 1'b1;
    endtask

    // Command-level behaviour for one clock edge, from the current inputs.
    task automatic model_step();
        m_cmplt = 1'b0;
        case (m_mode)
            M_IDLE: begin
                if (strt_hdng) begin
                    m_hdng = cmd_hdng;
                    m_cnt  = 0;
                    m_mode = M_TURN;
                end else if (strt_mv) begin
                    m_spd  = MIN_S;
                    m_mode = M_UP;
                end
            end
            M_TURN: begin
                if (hdng_vld) begin
                    m_cnt = at_hdng ? m_cnt + 1 : 0;
                    if (m_cnt == SETTLE) begin
                        m_cnt   = 0;
                        m_mode  = M_IDLE;
                        m_cmplt = 1'b1;
                    end
                end
            end
            M_UP: begin
                if (hard_stp) model_stop();
                else begin
                    if (hdng_vld) m_spd = (m_spd + INC_S > MAX_S) ? MAX_S : m_spd + INC_S;
                    if (stp_mv) m_mode = M_DOWN;
                end
            end
            default: begin
                if (hard_stp) model_stop();
                else if (hdng_vld) begin
                    if (m_spd <= DEC_S) model_stop();
                    else m_spd = m_spd - DEC_S;
                end
            end
        endcase
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample(input logic at);
        hdng_vld = 1'b1;
        at_hdng  = at;
        tick();
        hdng_vld = 1'b0;
        at_hdng  = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; strt_hdng = 0; strt_mv = 0; stp_mv = 0; hard_stp = 0;
        cmd_hdng = '0; hdng_vld = 0; at_hdng = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        n_tests++; if (dsrd_hdng !== 12'h000) begin n_fail++; $display("FAIL reset_dsrd_hdng got=%h exp=000", dsrd_hdng); end
        n_tests++; if (frwrd_spd !== 11'h000) begin n_fail++; $display("FAIL reset_frwrd_spd got=%h exp=000", frwrd_spd); end
        n_tests++; if (moving !== 1'b0) begin n_fail++; $display("FAIL reset_moving got=%b exp=0", moving); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
        n_tests++; if (mv_cmplt !== 1'b0) begin n_fail++; $display("FAIL reset_mv_cmplt got=%b exp=0", mv_cmplt); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset_mid_accel();
        strt_mv = 1'b1; tick(); strt_mv = 1'b0;
        sample(1'b0);
        sample(1'b0);
        n_tests++; if (frwrd_spd !== 11'h100) begin n_fail++; $display("FAIL rstmid_pre_spd got=%h exp=100", frwrd_spd); end
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        n_tests++; if (frwrd_spd !== 11'h000) begin n_fail++; $display("FAIL rstmid_spd got=%h exp=000", frwrd_spd); end
        n_tests++; if ({moving, busy, mv_cmplt} !== 3'b000) begin n_fail++; $display("FAIL rstmid_flags got=%b exp=000", {moving, busy, mv_cmplt}); end
        rst_n = 1'b1;
        tick();
        n_tests++; if ({busy, mv_cmplt} !== 2'b00) begin n_fail++; $display("FAIL rstmid_after got=%b exp=00", {busy, mv_cmplt}); end
    endtask

    task automatic test_turn_settle();
        logic pat [7];
        pat = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        cmd_hdng = 12'h3FF; strt_hdng = 1'b1; tick(); strt_hdng = 1'b0; cmd_hdng = 12'h000;
        n_tests++; if (dsrd_hdng !== 12'h3FF) begin n_fail++; $display("FAIL turn_dsrd got=%h exp=3FF", dsrd_hdng); end
        n_tests++; if ({busy, moving} !== 2'b11) begin n_fail++; $display("FAIL turn_busy got=%b exp=11", {busy, moving}); end
        for (int i = 0; i < 7; i++) begin
            repeat ($urandom_range(0, 2)) begin
                at_hdng = 1'($urandom_range(0, 1));
                tick();
                at_hdng = 1'b0;
            end
            sample(pat[i]);
            n_tests++; if (mv_cmplt !== (i == 6)) begin n_fail++; $display("FAIL turn_cmplt sample=%0d got=%b exp=%b", i + 1, mv_cmplt, (i == 6)); end
            n_tests++; if (frwrd_spd !== 11'h000) begin n_fail++; $display("FAIL turn_spd sample=%0d got=%h exp=000", i + 1, frwrd_spd); end
        end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL turn_done_busy got=%b exp=0", busy); end
        tick();
        n_tests++; if (mv_cmplt !== 1'b0) begin n_fail++; $display("FAIL turn_cmplt_width got=%b exp=0", mv_cmplt); end
        n_tests++; if (dsrd_hdng !== 12'h3FF) begin n_fail++; $display("FAIL turn_hold_hdng got=%h exp=3FF", dsrd_hdng); end
    endtask

    task automatic test_accel();
        int exp_spd;
        strt_mv = 1'b1; tick(); strt_mv = 1'b0;
        n_tests++; if (frwrd_spd !== 11'(MIN_S)) begin n_fail++; $display("FAIL accel_start got=%h exp=%h", frwrd_spd, 11'(MIN_S)); end
        for (int k = 1; k <= 25; k++) begin
            exp_spd = MIN_S + INC_S * k;
            if (exp_spd > MAX_S) exp_spd = MAX_S;
            repeat ($urandom_range(0, 2)) tick();
            sample(1'($urandom_range(0, 1)));
            n_tests++; if (frwrd_spd !== 11'(exp_spd)) begin n_fail++; $display("FAIL accel_spd sample=%0d got=%h exp=%h", k, frwrd_spd, 11'(exp_spd)); end
        end
        tick();
        n_tests++; if (frwrd_spd !== 11'h2A0) begin n_fail++; $display("FAIL accel_hold got=%h exp=2A0", frwrd_spd); end
    endtask

    task automatic test_decel();
        logic [10:0] exp_tab [7];
        exp_tab = '{11'h240, 11'h1E0, 11'h180, 11'h120, 11'h0C0, 11'h060, 11'h000};
        stp_mv = 1'b1; tick(); stp_mv = 1'b0;
        n_tests++; if (frwrd_spd !== 11'h2A0 || busy !== 1'b1) begin n_fail++; $display("FAIL decel_entry got=%h/%b exp=2A0/1", frwrd_spd, busy); end
        for (int i = 0; i < 7; i++) begin
            repeat ($urandom_range(0, 2)) tick();
            sample(1'b0);
            n_tests++; if (frwrd_spd !== exp_tab[i]) begin n_fail++; $display("FAIL decel_spd sample=%0d got=%h exp=%h", i + 1, frwrd_spd, exp_tab[i]); end
            n_tests++; if (mv_cmplt !== (i == 6) || busy !== (i != 6)) begin n_fail++; $display("FAIL decel_flags sample=%0d got=%b%b exp=%b%b", i + 1, mv_cmplt, busy, (i == 6), (i != 6)); end
        end
    endtask

    task automatic test_hard_stp();
        strt_mv = 1'b1; tick(); strt_mv = 1'b0;
        repeat (4) sample(1'b1);
        n_tests++; if (frwrd_spd !== 11'h130) begin n_fail++; $display("FAIL hstp_pre got=%h exp=130", frwrd_spd); end
        hard_stp = 1'b1; tick();
        n_tests++; if (frwrd_spd !== 11'h000 || mv_cmplt !== 1'b1) begin n_fail++; $display("FAIL hstp_stop got=%h/%b exp=000/1", frwrd_spd, mv_cmplt); end
        n_tests++; if ({moving, busy} !== 2'b00) begin n_fail++; $display("FAIL hstp_idle got=%b exp=00", {moving, busy}); end
        tick(); hard_stp = 1'b0;
        n_tests++; if (mv_cmplt !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL hstp_after got=%b/%b exp=0/0", mv_cmplt, busy); end
    endtask

    task automatic test_both_start();
        logic [11:0] h;
        h = 12'($urandom);
        cmd_hdng = h; strt_hdng = 1'b1; strt_mv = 1'b1; tick();
        strt_hdng = 1'b0; strt_mv = 1'b0;
        n_tests++; if (busy !== 1'b1 || frwrd_spd !== 11'h000 || dsrd_hdng !== h) begin n_fail++; $display("FAIL both_turn got=%b/%h/%h exp=1/000/%h", busy, frwrd_spd, dsrd_hdng, h); end
        strt_mv = 1'b1; hard_stp = 1'b1; tick(); strt_mv = 1'b0; hard_stp = 1'b0;
        n_tests++; if (busy !== 1'b1 || frwrd_spd !== 11'h000 || mv_cmplt !== 1'b0) begin n_fail++; $display("FAIL both_ignored got=%b/%h/%b exp=1/000/0", busy, frwrd_spd, mv_cmplt); end
        repeat (3) sample(1'b1);
        n_tests++; if (mv_cmplt !== 1'b0 || frwrd_spd !== 11'h000) begin n_fail++; $display("FAIL both_pre got=%b/%h exp=0/000", mv_cmplt, frwrd_spd); end
        sample(1'b1);
        n_tests++; if (mv_cmplt !== 1'b1) begin n_fail++; $display("FAIL both_cmplt got=%b exp=1", mv_cmplt); end
    endtask

    task automatic test_back_to_back();
        // mv_cmplt cycle from the previous turn: issue a move immediately
        strt_mv = 1'b1; tick(); strt_mv = 1'b0;
        n_tests++; if (busy !== 1'b1 || frwrd_spd !== 11'(MIN_S)) begin n_fail++; $display("FAIL b2b_mv got=%b/%h exp=1/0D0", busy, frwrd_spd); end
        stp_mv = 1'b1; hdng_vld = 1'b1; tick(); stp_mv = 1'b0; hdng_vld = 1'b0;
        n_tests++; if (frwrd_spd !== 11'(MIN_S + INC_S)) begin n_fail++; $display("FAIL b2b_stp_inc got=%h exp=%h", frwrd_spd, 11'(MIN_S + INC_S)); end
        sample(1'b0);
        n_tests++; if (frwrd_spd !== 11'(MIN_S + INC_S - DEC_S)) begin n_fail++; $display("FAIL b2b_decel got=%h exp=%h", frwrd_spd, 11'(MIN_S + INC_S - DEC_S)); end
        hard_stp = 1'b1; tick(); hard_stp = 1'b0;
        cmd_hdng = 12'h801; strt_hdng = 1'b1; tick(); strt_hdng = 1'b0;
        n_tests++; if (busy !== 1'b1 || dsrd_hdng !== 12'h801) begin n_fail++; $display("FAIL b2b_turn got=%b/%h exp=1/801", busy, dsrd_hdng); end
        repeat (SETTLE) sample(1'b1);
    endtask

    task automatic test_random();
        for (int c = 0; c < 3000; c++) begin
            strt_hdng = ($urandom_range(0, 5) == 0);
            strt_mv   = ($urandom_range(0, 4) == 0);
            stp_mv    = ($urandom_range(0, 14) == 0);
            hard_stp  = ($urandom_range(0, 39) == 0);
            hdng_vld  = ($urandom_range(0, 1) == 0);
            at_hdng   = ($urandom_range(0, 3) != 0);
            cmd_hdng  = 12'($urandom);
            tick();
            n_tests++; if (frwrd_spd !== 11'(m_spd)) begin n_fail++; $display("FAIL rand_spd cyc=%0d got=%h exp=%h", c, frwrd_spd, 11'(m_spd)); end
            n_tests++; if (mv_cmplt !== m_cmplt) begin n_fail++; $display("FAIL rand_cmplt cyc=%0d got=%b exp=%b", c, mv_cmplt, m_cmplt); end
            n_tests++; if (busy !== (m_mode != M_IDLE) || moving !== (m_mode != M_IDLE)) begin n_fail++; $display("FAIL rand_busy cyc=%0d got=%b%b exp=%b", c, busy, moving, (m_mode != M_IDLE)); end
            n_tests++; if (dsrd_hdng !== m_hdng) begin n_fail++; $display("FAIL rand_hdng cyc=%0d got=%h exp=%h", c, dsrd_hdng, m_hdng); end
        end
        strt_hdng = 0; strt_mv = 0; stp_mv = 0; hard_stp = 0; hdng_vld = 0; at_hdng = 0;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        test_reset();
        test_reset_mid_accel();
        test_turn_settle();
        test_accel();
        test_decel();
        test_hard_stp();
        test_both_start();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
